// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box, xtime, key-length check and datapath widths.
package aes_pkg;

    localparam int AES_WORD_W  = 32;
    localparam int AES_BLOCK_W = 128;

    typedef enum logic {IDLE, EXPAND} sched_state_t;

    // FIPS-197 S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] aes_sbox(input logic [7:0] b);
        return SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic bit aes_nk_legal(input int nk);
        return (nk == 4) || (nk == 6) || (nk == 8);
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: the S-box applied to each byte of a 32-bit word.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [AES_WORD_W-1:0] word,
    output logic [AES_WORD_W-1:0] sub
);

    always_comb begin
        sub = '0;
        for (int k = 0; k < 4; k++) begin
            sub[8*k +: 8] = aes_sbox(word[8*k +: 8]);
        end
    end

endmodule

// File: rtl/aes_key_sched.sv
// Iterative AES key expansion: one schedule word per cycle into a register array,
// with round keys read back combinationally once the schedule is complete.
//
// state  | meaning
// IDLE   | waiting for start; schedule valid if key_valid=1
// EXPAND | writing w[idx] each cycle until w[NW-1]
module aes_key_sched
    import aes_pkg::*;
#(
    parameter int NK = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [32*NK-1:0]         key,
    output logic                     busy,
    output logic                     done,
    output logic                     key_valid,
    input  logic [3:0]               rd_round,
    output logic [AES_BLOCK_W-1:0]   rd_key
);

    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);

    if (!aes_nk_legal(NK)) begin : g_bad_nk
        $error("aes_key_sched: NK must be 4, 6 or 8");
    end

    localparam logic [5:0] NK_W   = 6'(NK);
    localparam logic [5:0] LAST_W = 6'(NW - 1);
    localparam logic [2:0] MOD_MAX = 3'(NK - 1);
    localparam logic [3:0] NR_W   = 4'(NR);

    sched_state_t          state;
    logic [5:0]            idx;
    logic [2:0]            mod_cnt;
    logic [7:0]            rcon;
    logic [AES_WORD_W-1:0] w [NW];

    logic [AES_WORD_W-1:0] prev, old, sub_in, sub_out, t, new_word;

    assign prev   = w[idx - 6'd1];
    assign old    = w[idx - NK_W];
    assign sub_in = (mod_cnt == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

    // A single S-box lookup serves both the RotWord and the NK=8 mid-key cases.
    aes_sub_word u_sub_word (
        .word (sub_in),
        .sub  (sub_out)
    );

    always_comb begin
        t = prev;
        if (mod_cnt == 3'd0) begin
            t = sub_out ^ {rcon, 24'h0};
        end else if (NK == 8 && mod_cnt == 3'd4) begin
            t = sub_out;
        end
        new_word = old ^ t;
    end

    assign busy = (state == EXPAND);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            done      <= 1'b0;
            key_valid <= 1'b0;
            idx       <= '0;
            mod_cnt   <= '0;
            rcon      <= 8'h01;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        key_valid <= 1'b0;
                        idx       <= NK_W;
                        mod_cnt   <= '0;
                        rcon      <= 8'h01;
                        state     <= EXPAND;
                    end
                end
                EXPAND: begin
                    idx     <= idx + 6'd1;
                    mod_cnt <= (mod_cnt == MOD_MAX) ? 3'd0 : mod_cnt + 3'd1;
                    if (mod_cnt == 3'd0) begin
                        rcon <= xtime(rcon);
                    end
                    if (idx == LAST_W) begin
                        state     <= IDLE;
                        done      <= 1'b1;
                        key_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Word storage is unreset; key_valid masks it on the read side.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            for (int k = 0; k < NK; k++) begin
                w[k] <= key[AES_WORD_W*(NK-k)-1 -: AES_WORD_W];
            end
        end else if (state == EXPAND) begin
            w[idx] <= new_word;
        end
    end

    always_comb begin
        rd_key = '0;
        if (key_valid && rd_round <= NR_W) begin
            rd_key = {w[{rd_round, 2'b00}], w[{rd_round, 2'b01}],
                      w[{rd_round, 2'b10}], w[{rd_round, 2'b11}]};
        end
    end

endmodule

// File: tb/tb_aes_key_sched.sv
// Directed bench for aes_key_sched with NK=4, 6 and 8 instances on one clock.
module tb_aes_key_sched;
    import aes_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start4 = 0, start6 = 0, start8 = 0;
    logic [127:0]  key4 = '0;
    logic [191:0]  key6 = '0;
    logic [255:0]  key8 = '0;
    logic [3:0]    rr4 = 0, rr6 = 0, rr8 = 0;
    logic          busy4, busy6, busy8, done4, done6, done8, kv4, kv6, kv8;
    logic [127:0]  rk4, rk6, rk8;

    aes_key_sched #(.NK(4)) dut4 (.clk(clk), .rst_n(rst_n), .start(start4), .key(key4),
        .busy(busy4), .done(done4), .key_valid(kv4), .rd_round(rr4), .rd_key(rk4));
    aes_key_sched #(.NK(6)) dut6 (.clk(clk), .rst_n(rst_n), .start(start6), .key(key6),
        .busy(busy6), .done(done6), .key_valid(kv6), .rd_round(rr6), .rd_key(rk6));
    aes_key_sched #(.NK(8)) dut8 (.clk(clk), .rst_n(rst_n), .start(start8), .key(key8),
        .busy(busy8), .done(done8), .key_valid(kv8), .rd_round(rr8), .rd_key(rk8));

    localparam logic [127:0] K4     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K6     = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K8     = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R4_1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R4_10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] R6_12  = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] R8_2   = 128'h9ba354118e6925afa51a8b5f2067fcde;
    localparam logic [127:0] R8_14  = 128'hfe4890d1e6188d0b046df344706c631e;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Returns edges from the start edge to the done pulse, or -1 if none within budget.
    task automatic wait_done(input int sel, output int n);
        logic d;
        n = -1;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            d = (sel == 4) ? done4 : (sel == 6) ? done6 : done8;
            if (d) begin
                n = c;
                break;
            end
        end
    endtask

    task automatic pulse_start(input int sel);
        @(negedge clk);
        if (sel == 4) start4 = 1; else if (sel == 6) start6 = 1; else start8 = 1;
        @(posedge clk); #1;
        start4 = 0; start6 = 0; start8 = 0;
    endtask

    initial begin
        int n;
        logic seen;

        #12;
        chk("rst_busy", 128'(busy4), 128'd0);
        chk("rst_done", 128'(done4), 128'd0);
        chk("rst_key_valid", 128'(kv4), 128'd0);
        chk("rst_rd_key", rk4, 128'd0);
        @(negedge clk) rst_n = 1;

        // NK=4 basic expansion
        key4 = K4;
        pulse_start(4);
        chk("nk4_busy_after_start", 128'(busy4), 128'd1);
        wait_done(4, n);
        chk("nk4_latency", 128'(n), 128'd40);
        chk("nk4_key_valid", 128'(kv4), 128'd1);
        chk("nk4_busy_idle", 128'(busy4), 128'd0);
        rr4 = 0; #1 chk("nk4_r0", rk4, K4);
        rr4 = 1; #1 chk("nk4_r1", rk4, R4_1);
        rr4 = 10; #1 chk("nk4_r10", rk4, R4_10);
        rr4 = 15; #1 chk("nk4_r15_zero", rk4, 128'd0);
        @(posedge clk); #1;
        chk("nk4_done_one_cycle", 128'(done4), 128'd0);

        // Restart from valid schedule; a mid-run start with a zero key is ignored
        rr4 = 1;
        pulse_start(4);
        chk("nk4b_key_valid_cleared", 128'(kv4), 128'd0);
        chk("nk4b_rd_busy_zero", rk4, 128'd0);
        n = -1;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            if (c == 10) begin start4 = 1; key4 = '0; end
            if (c == 11) start4 = 0;
            if (done4) begin n = c; break; end
        end
        chk("nk4b_latency", 128'(n), 128'd40);
        rr4 = 1; #1 chk("nk4b_r1", rk4, R4_1);
        rr4 = 10; #1 chk("nk4b_r10", rk4, R4_10);

        // NK=6
        key6 = K6;
        pulse_start(6);
        wait_done(6, n);
        chk("nk6_latency", 128'(n), 128'd46);
        rr6 = 0; #1 chk("nk6_r0", rk6, K6[191:64]);
        rr6 = 12; #1 chk("nk6_r12", rk6, R6_12);
        rr6 = 13; #1 chk("nk6_r13_zero", rk6, 128'd0);

        // NK=8
        key8 = K8;
        pulse_start(8);
        wait_done(8, n);
        chk("nk8_latency", 128'(n), 128'd52);
        rr8 = 1; #1 chk("nk8_r1", rk8, K8[127:0]);
        rr8 = 2; #1 chk("nk8_r2", rk8, R8_2);
        rr8 = 14; #1 chk("nk8_r14", rk8, R8_14);

        // Reset in the middle of an NK=8 expansion
        pulse_start(8);
        repeat (20) @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("abort_busy", 128'(busy8), 128'd0);
        chk("abort_key_valid", 128'(kv8), 128'd0);
        chk("abort_rd_key", rk8, 128'd0);
        @(negedge clk) rst_n = 1;
        seen = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (done8) seen = 1;
        end
        chk("abort_no_done", 128'(seen), 128'd0);
        chk("abort_rd_key_after", rk8, 128'd0);
        pulse_start(8);
        wait_done(8, n);
        chk("nk8c_latency", 128'(n), 128'd52);
        chk("nk8c_r14", rk8, R8_14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
